// File: rtl/cam_result_bank_array_if.sv
// Command and read-beat handshake bundle for the CAM result bank array.
// The master drives commands and consumes read beats; the slave is the bank array.
interface cam_result_bank_array_if #(
  parameter int DATA_WIDTH     = 4,
  parameter int DATA_DEPTH     = 4,
  parameter int ADDR_WIDTH_CAM = 8,
  parameter int BANK_AW        = 1
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [2:0]                cmd_op;
  logic [BANK_AW-1:0]        cmd_bank;
  logic [ADDR_WIDTH_CAM-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0]     Ip_row;
  logic [DATA_DEPTH-1:0]     Ip_col;
  logic                      rd_valid;
  logic                      rd_ready;
  logic [DATA_WIDTH-1:0]     rd_row;
  logic [DATA_DEPTH-1:0]     rd_col;
  logic                      rd_last;

  modport master (
    output cmd_valid, cmd_op, cmd_bank, cmd_addr, Ip_row, Ip_col, rd_ready,
    input  cmd_ready, rd_valid, rd_row, rd_col, rd_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_bank, cmd_addr, Ip_row, Ip_col, rd_ready,
    output cmd_ready, rd_valid, rd_row, rd_col, rd_last
  );
endinterface

// File: rtl/cam_result_bank_array.sv
// Multi-bank CAM result register array with command front end, tagged write-back
// and a registered read port that serves single row/column reads and whole-bank dumps.
//   state   | meaning
//   IDLE    | accepting commands
//   RD_HOLD | single row/col beat presented, waiting for rd_ready
//   DUMP    | streaming rows of dump_bank_q, one per handshake
module cam_result_bank_array #(
  parameter int DATA_WIDTH     = 4,
  parameter int DATA_DEPTH     = 4,
  parameter int ADDR_WIDTH_CAM = 8,
  parameter int NUM_BANKS      = 2,
  parameter int BANK_AW        = 1
) (
  input  logic                             clk,
  input  logic                             rstIn,
  cam_result_bank_array_if.slave           bus,
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] Q_A,
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] Q_B,
  input  logic [DATA_DEPTH-1:0]            Q_S,
  input  logic [DATA_DEPTH-1:0]            tag,
  input  logic [DATA_WIDTH-1:0]            Mask,
  input  logic                             abs_opt,
  input  logic [2:0]                       Pass,
  input  logic                             wb_en,
  input  logic [BANK_AW-1:0]               act_bank,
  output logic [DATA_WIDTH*DATA_DEPTH-1:0] Q
);
  localparam int NB = DATA_WIDTH * DATA_DEPTH;
  localparam int RW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_HOLD = 2'd1;
  localparam logic [1:0] DUMP    = 2'd2;

  localparam logic [2:0] OP_DUMP   = 3'd0;
  localparam logic [2:0] OP_WR_ROW = 3'd1;
  localparam logic [2:0] OP_WR_COL = 3'd2;
  localparam logic [2:0] OP_COPY_B = 3'd3;
  localparam logic [2:0] OP_RD_ROW = 3'd4;
  localparam logic [2:0] OP_COPY_A = 3'd5;
  localparam logic [2:0] OP_CLEAR  = 3'd6;
  localparam logic [2:0] OP_RD_COL = 3'd7;

  logic [NB-1:0]         bank_q [NUM_BANKS];
  logic [NB-1:0]         bank_d [NUM_BANKS];
  logic [1:0]            state_q, state_d;
  logic [RW-1:0]         dump_row_q, dump_row_d;
  logic [BANK_AW-1:0]    dump_bank_q, dump_bank_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_last_q, rd_last_d;
  logic [DATA_WIDTH-1:0] rd_row_q, rd_row_d;
  logic [DATA_DEPTH-1:0] rd_col_q, rd_col_d;

  logic [ADDR_WIDTH_CAM-1:0] addr_w;
  logic [BANK_AW-1:0]        bank_w;
  logic                      cmd_fire;
  logic [NB-1:0]             cmd_arr, dump_arr;

  assign addr_w   = bus.cmd_addr;
  assign bank_w   = bus.cmd_bank;
  assign cmd_fire = bus.cmd_valid && (state_q == IDLE);

  function automatic logic [DATA_WIDTH-1:0] row_of(input logic [NB-1:0] arr, input int r);
    row_of = '0;
    for (int i = 0; i < DATA_DEPTH; i++)
      for (int j = 0; j < DATA_WIDTH; j++)
        if (i == r) row_of[j] = arr[i*DATA_WIDTH+j];
  endfunction

  function automatic logic [DATA_DEPTH-1:0] col_of(input logic [NB-1:0] arr, input int c);
    col_of = '0;
    for (int i = 0; i < DATA_DEPTH; i++)
      for (int j = 0; j < DATA_WIDTH; j++)
        if (j == c) col_of[i] = arr[i*DATA_WIDTH+j];
  endfunction

  // Out-of-range bank selects resolve to all-zero arrays.
  always_comb begin
    cmd_arr  = '0;
    dump_arr = '0;
    Q        = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (int'(bank_w) == b)      cmd_arr  = bank_q[b];
      if (int'(dump_bank_q) == b) dump_arr = bank_q[b];
      if (int'(act_bank) == b)    Q        = bank_q[b];
    end
  end

  // Later assignments win: write-back < row/col write < copy < clear.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_d[b] = bank_q[b];
      if (wb_en && int'(act_bank) == b) begin
        for (int i = 0; i < DATA_DEPTH; i++)
          for (int j = 0; j < DATA_WIDTH; j++)
            if (tag[i] && Mask[j]) begin
              if (abs_opt)
                bank_d[b][i*DATA_WIDTH+j] = Q_A[i*DATA_WIDTH+j] ^
                  (Q_S[i] && (Pass == 3'd2 || Pass == 3'd3));
              else
                bank_d[b][i*DATA_WIDTH+j] = Q_A[i*DATA_WIDTH+j] ^
                  (Pass == 3'd1 || Pass == 3'd2);
            end
      end
      if (cmd_fire && int'(bank_w) == b) begin
        case (bus.cmd_op)
          OP_WR_ROW:
            for (int i = 0; i < DATA_DEPTH; i++)
              for (int j = 0; j < DATA_WIDTH; j++)
                if (i == int'(addr_w)) bank_d[b][i*DATA_WIDTH+j] = bus.Ip_row[j];
          OP_WR_COL:
            for (int i = 0; i < DATA_DEPTH; i++)
              for (int j = 0; j < DATA_WIDTH; j++)
                if (j == int'(addr_w)) bank_d[b][i*DATA_WIDTH+j] = bus.Ip_col[i];
          OP_COPY_A: bank_d[b] = Q_A;
          OP_COPY_B: bank_d[b] = Q_B;
          OP_CLEAR:  bank_d[b] = '0;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    dump_row_d  = dump_row_q;
    dump_bank_d = dump_bank_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    rd_row_d    = rd_row_q;
    rd_col_d    = rd_col_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          case (bus.cmd_op)
            OP_DUMP: begin
              state_d     = DUMP;
              dump_bank_d = bank_w;
              dump_row_d  = '0;
              rd_valid_d  = 1'b1;
              rd_row_d    = row_of(cmd_arr, 0);
              rd_col_d    = '0;
              rd_last_d   = (DATA_DEPTH == 1);
            end
            OP_RD_ROW: begin
              state_d    = RD_HOLD;
              rd_valid_d = 1'b1;
              rd_row_d   = row_of(cmd_arr, int'(addr_w));
              rd_col_d   = '0;
              rd_last_d  = 1'b1;
            end
            OP_RD_COL: begin
              state_d    = RD_HOLD;
              rd_valid_d = 1'b1;
              rd_row_d   = '0;
              rd_col_d   = col_of(cmd_arr, int'(addr_w));
              rd_last_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      RD_HOLD: begin
        if (rd_valid_q && bus.rd_ready) begin
          state_d    = IDLE;
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          rd_row_d   = '0;
          rd_col_d   = '0;
        end
      end
      DUMP: begin
        if (rd_valid_q && bus.rd_ready) begin
          if (rd_last_q) begin
            state_d    = IDLE;
            dump_row_d = '0;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            rd_row_d   = '0;
          end else begin
            // Next row is sampled now, so later rows see writes made mid-dump.
            dump_row_d = dump_row_q + RW'(1);
            rd_row_d   = row_of(dump_arr, int'(dump_row_q) + 1);
            rd_last_d  = (int'(dump_row_q) + 1 == DATA_DEPTH - 1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstIn) begin
      bank_q      <= '{default: '0};
      state_q     <= IDLE;
      dump_row_q  <= '0;
      dump_bank_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
    end else begin
      bank_q      <= bank_d;
      state_q     <= state_d;
      dump_row_q  <= dump_row_d;
      dump_bank_q <= dump_bank_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.rd_row    = rd_row_q;
  assign bus.rd_col    = rd_col_q;
endmodule
